// File: rtl/fetch_unit_if.sv
// Handshake/bus bundle for the fetch stage: instruction-memory read port,
// redirect input, decoder-facing valid/ready output and the stop flag.
interface fetch_unit_if #(
   parameter int XLEN = 64
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic [XLEN-1:0] out_pc;
   logic            stop;

   // Fetch-unit side
   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, stop,
      input  imem_rdata, redirect, redirect_pc, out_ready
   );

   // Environment side (memory, branch logic, decoder)
   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, stop,
      output imem_rdata, redirect, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to a
// 1-cycle-latency instruction memory, buffers {instr, pc} in a small
// circular FIFO and hands them to the decoder over valid/ready.
module fetch_unit #(
   parameter int              XLEN      = 64,
   parameter int              DEPTH     = 2,
   parameter int              NUM_INSTR = 15,
   parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = CW + 1;
   localparam int AW = XLEN - 2;

   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] inflight_pc_r;
   logic            inflight_r;
   logic            stop_r;
   logic [31:0]     buf_instr_r [DEPTH];
   logic [XLEN-1:0] buf_pc_r    [DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [CW-1:0]   count_r;

   logic            valid_s;
   logic            pop_s;
   logic            in_range_s;
   logic [OW-1:0]   occupancy_s;
   logic            issue_s;
   logic            capture_s;
   logic            stop_cond_s;
   logic [XLEN-1:0] target_s;
   logic            target_in_range_s;

   // Advance a FIFO pointer modulo DEPTH
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == PW'(DEPTH - 1)) begin
         n = {PW{1'b0}};
      end else begin
         n = p + PW'(1);
      end
      return n;
   endfunction

   // Issue/capture/pop decisions derived from registered state and inputs
   always_comb begin
      valid_s           = (count_r != {CW{1'b0}});
      pop_s             = valid_s & bus.out_ready;
      in_range_s        = (fetch_pc_r[XLEN-1:2] < AW'(NUM_INSTR));
      // Slots already committed (buffered + in flight) once this cycle's pop leaves
      occupancy_s       = OW'(count_r) + OW'(inflight_r) - OW'(pop_s);
      issue_s           = !rst & !bus.redirect & in_range_s & (occupancy_s < OW'(DEPTH));
      capture_s         = inflight_r & !bus.redirect;
      stop_cond_s       = !in_range_s & !valid_s & !inflight_r;
      target_s          = bus.redirect_pc & {{AW{1'b1}}, 2'b00};
      target_in_range_s = (target_s[XLEN-1:2] < AW'(NUM_INSTR));
   end

   // Drive the bus outputs from the FIFO head and registered flags
   always_comb begin
      bus.imem_req  = issue_s;
      bus.imem_addr = fetch_pc_r;
      bus.out_valid = valid_s;
      bus.out_instr = buf_instr_r[head_r];
      bus.out_pc    = buf_pc_r[head_r];
      bus.stop      = stop_r;
   end

   // Fetch PC, in-flight tracking, FIFO storage/pointers and stop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         inflight_pc_r <= {XLEN{1'b0}};
         inflight_r    <= 1'b0;
         stop_r        <= 1'b0;
         head_r        <= {PW{1'b0}};
         tail_r        <= {PW{1'b0}};
         count_r       <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_r[i] <= 32'h0000_0000;
            buf_pc_r[i]    <= {XLEN{1'b0}};
         end
      end else if (bus.redirect) begin
         // Flush everything; the response of any in-flight read is dropped.
         // The buffer will be empty and idle, so stop follows the target alone.
         fetch_pc_r <= target_s;
         inflight_r <= 1'b0;
         head_r     <= {PW{1'b0}};
         tail_r     <= {PW{1'b0}};
         count_r    <= {CW{1'b0}};
         stop_r     <= !target_in_range_s;
      end else begin
         stop_r <= stop_cond_s;
         if (pop_s) begin
            head_r <= next_ptr(head_r);
         end else begin
            head_r <= head_r;
         end
         if (capture_s) begin
            buf_instr_r[tail_r] <= bus.imem_rdata;
            buf_pc_r[tail_r]    <= inflight_pc_r;
            tail_r              <= next_ptr(tail_r);
         end else begin
            tail_r <= tail_r;
         end
         count_r <= count_r + CW'(capture_s) - CW'(pop_s);
         if (issue_s) begin
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
            fetch_pc_r    <= fetch_pc_r + XLEN'(4);
         end else begin
            inflight_r <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based behavioural model of the
// fetch stream, directed scenarios with hand-computed expectations, and a
// randomized redirect/backpressure phase.
module tb_fetch_unit;
   localparam int XLEN      = 64;
   localparam int DEPTH     = 2;
   localparam int NUM_INSTR = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(XLEN)) bus ();

   fetch_unit #(
      .XLEN(XLEN), .DEPTH(DEPTH), .NUM_INSTR(NUM_INSTR), .RESET_PC(64'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Memory contents: word i = 0x13 + (i << 7)
   function automatic logic [31:0] word_at(input logic [63:0] pc);
      logic [63:0] idx;
      idx = pc >> 2;
      return 32'h0000_0013 + (idx[31:0] << 7);
   endfunction

   // Instruction memory with 1-cycle latency; garbage when not requested
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= word_at(bus.imem_addr);
      else              bus.imem_rdata <= $urandom;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the fetch stream as a queue of {instr, pc}
   logic [63:0] m_fpc;
   logic [63:0] m_ipc;
   bit          m_infl;
   bit          m_stop;
   logic [95:0] m_q[$];
   int          cyc;

   logic        s_valid, s_req, s_stop;
   logic [31:0] s_instr;
   logic [63:0] s_pc, s_addr;

   task automatic model_reset();
      m_fpc  = 64'h0;
      m_ipc  = 64'h0;
      m_infl = 1'b0;
      m_stop = 1'b0;
      m_q.delete();
   endtask

   // One clock cycle: drive inputs, sample, compare against the model, advance it
   task automatic step(input bit r, input logic [63:0] rpc, input bit rdy);
      bit   m_valid, m_pop, m_req, inr, stop_n;
      logic [63:0] tgt;
      @(negedge clk);
      bus.redirect    = r;
      bus.redirect_pc = rpc;
      bus.out_ready   = rdy;
      #1;
      s_valid = bus.out_valid;
      s_instr = bus.out_instr;
      s_pc    = bus.out_pc;
      s_req   = bus.imem_req;
      s_addr  = bus.imem_addr;
      s_stop  = bus.stop;

      m_valid = (m_q.size() > 0);
      inr     = ((m_fpc >> 2) < 64'(NUM_INSTR));
      m_pop   = m_valid && rdy;
      m_req   = !r && inr && ((m_q.size() + int'(m_infl) - int'(m_pop)) < DEPTH);

      chk("out_valid", 64'(s_valid), 64'(m_valid));
      if (m_valid) begin
         chk("out_pc", s_pc, m_q[0][63:0]);
         chk("out_instr", 64'(s_instr), 64'(m_q[0][95:64]));
      end
      chk("imem_req", 64'(s_req), 64'(m_req));
      if (m_req) chk("imem_addr", s_addr, m_fpc);
      chk("stop", 64'(s_stop), 64'(m_stop));
      chk("fifo_bound", 64'(int'(dut.count_r) <= DEPTH), 64'(1));

      if (r) begin
         tgt    = rpc & ~64'h3;
         m_q.delete();
         m_infl = 1'b0;
         m_fpc  = tgt;
         m_stop = ((tgt >> 2) >= 64'(NUM_INSTR));
      end else begin
         stop_n = !inr && (m_q.size() == 0) && !m_infl;
         if (m_pop) void'(m_q.pop_front());
         if (m_infl) m_q.push_back({word_at(m_ipc), m_ipc});
         if (m_req) begin
            m_ipc = m_fpc;
            m_fpc = m_fpc + 64'h4;
         end
         m_infl = m_req;
         m_stop = stop_n;
      end
      cyc++;
   endtask

   // Assert reset between clock edges, check outputs immediately, release between edges
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst             = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.out_ready   = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
      chk("rst_out_pc", bus.out_pc, 64'h0);
      chk("rst_imem_req", 64'(bus.imem_req), 64'h0);
      chk("rst_stop", 64'(bus.stop), 64'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      int c;
      int r_cyc;
      bit rr;
      logic [63:0] rp;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.out_ready   = 1'b1;
      cyc             = 0;
      model_reset();

      // Streaming with out_ready high
      do_reset();
      for (int k = 0; k < 22; k++) begin
         c = cyc;
         step(1'b0, 64'h0, 1'b1);
         if (c == 0)  begin chk("a_req0", 64'(s_req), 64'h1); chk("a_addr0", s_addr, 64'h0); end
         if (c == 1)  chk("a_novalid1", 64'(s_valid), 64'h0);
         if (c == 2)  begin chk("a_pc2", s_pc, 64'h0); chk("a_instr2", 64'(s_instr), 64'h13); end
         if (c == 3)  begin chk("a_pc3", s_pc, 64'h4); chk("a_instr3", 64'(s_instr), 64'h93); end
         if (c == 17) chk("a_stop17", 64'(s_stop), 64'h0);
         if (c == 18) chk("a_stop18", 64'(s_stop), 64'h1);
      end

      // Backpressure: out_ready low for cycles 2..7
      do_reset();
      for (int k = 0; k < 13; k++) begin
         c = cyc;
         step(1'b0, 64'h0, !(c >= 2 && c <= 7));
         if (c >= 3 && c <= 7) begin
            chk("b_hold_pc", s_pc, 64'h0);
            chk("b_hold_req", 64'(s_req), 64'h0);
         end
         if (c == 8)  chk("b_pc8", s_pc, 64'h0);
         if (c == 9)  chk("b_pc9", s_pc, 64'h4);
         if (c == 10) chk("b_pc10", s_pc, 64'h8);
      end

      // Redirect to 0x24 with one buffered and one in flight
      do_reset();
      step(1'b0, 64'h0, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      step(1'b1, 64'h24, 1'b0);
      chk("c_req_redir", 64'(s_req), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      chk("c_req_r1", 64'(s_req), 64'h1);
      chk("c_addr_r1", s_addr, 64'h24);
      chk("c_valid_r1", 64'(s_valid), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      chk("c_valid_r2", 64'(s_valid), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      chk("c_pc_r3", s_pc, 64'h24);
      chk("c_instr_r3", 64'(s_instr), 64'h493);

      // Misaligned redirect, run to stop, then out-of-range and back in range
      repeat (2) step(1'b0, 64'h0, 1'b1);
      step(1'b1, 64'h2E, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      chk("d_addr_2c", s_addr, 64'h2C);
      step(1'b0, 64'h0, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      chk("d_pc_2c", s_pc, 64'h2C);
      chk("d_instr_2c", 64'(s_instr), 64'h593);
      for (int k = 0; k < 40 && !s_stop; k++) step(1'b0, 64'h0, 1'b1);
      chk("d_stop_seen", 64'(s_stop), 64'h1);
      step(1'b1, 64'h100, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      chk("d_oor_stop", 64'(s_stop), 64'h1);
      chk("d_oor_req", 64'(s_req), 64'h0);
      step(1'b1, 64'h10, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      chk("d_stop_clr", 64'(s_stop), 64'h0);
      chk("d_addr_10", s_addr, 64'h10);

      // Redirect together with a pop
      step(1'b0, 64'h0, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      step(1'b1, 64'h8, 1'b1);
      chk("e_valid_at_redir", 64'(s_valid), 64'h1);
      step(1'b0, 64'h0, 1'b1);
      chk("e_empty_r1", 64'(s_valid), 64'h0);
      step(1'b0, 64'h0, 1'b1);
      step(1'b0, 64'h0, 1'b1);
      chk("e_pc_r3", s_pc, 64'h8);
      chk("e_instr_r3", 64'(s_instr), 64'h113);

      // Asynchronous reset mid-stream, then restart from pc 0
      repeat (2) step(1'b0, 64'h0, 1'b1);
      do_reset();
      for (int k = 0; k < 4; k++) begin
         c = cyc;
         step(1'b0, 64'h0, 1'b1);
         if (c == 1) chk("f_novalid1", 64'(s_valid), 64'h0);
         if (c == 2) begin chk("f_pc2", s_pc, 64'h0); chk("f_instr2", 64'(s_instr), 64'h13); end
      end

      // Randomized redirects and backpressure
      r_cyc = 0;
      for (int k = 0; k < 400; k++) begin
         rr = ($urandom_range(0, 19) == 0) || (s_stop && ($urandom_range(0, 1) == 0));
         rp = 64'($urandom_range(0, 19)) * 64'h4 + 64'($urandom_range(0, 3));
         if (k == 200) do_reset();
         step(rr, rp, ($urandom_range(0, 9) < 7));
         r_cyc++;
      end
      chk("g_cycles_run", 64'(r_cyc), 64'd400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
